imem_loader: RTL

//  Boot-time writer for the instruction memory that the core's fetch path reads.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/byte_packer.sv | 45 ++++
 rtl/imem_loader.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory boot loader: state encoding,
// memory depth and word geometry.
package riscv_pkg;

  localparam int IMEM_DEPTH     = 1024;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } loader_state_e;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word packer. `word` already includes the byte being
// accepted this cycle, so it is complete in the same cycle word_full pulses.
module byte_packer
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_fire,
  input  logic [7:0]        in_byte,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clr) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (in_fire) begin
      word_d[{cnt_q, 3'b000} +: 8] = in_byte;
      cnt_d = cnt_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word      = word_d;
  assign word_full = in_fire && !clr && (cnt_q == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer; holds the core in reset until a program
// is loaded. Optional trailing checksum word enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import riscv_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             core_rst,
  output logic             busy,
  output logic             done,
  output logic             err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  loader_state_e     state_q, state_d;
  logic [CNT_W-1:0]  word_idx_q, word_idx_d, num_q, num_d;
  logic [WORD_W-1:0] sum_q, sum_d;
  logic              ck_ok_q, ck_ok_d;
  logic              err_q, err_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;

  logic              start_ok, oversize, in_fire, word_full, last_word, ck_phase;
  logic [WORD_W-1:0] pk_word;

  assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign oversize  = num_words > CNT_W'(DEPTH);
  assign in_fire   = byte_valid && byte_ready;
  assign last_word = (word_idx_q + CNT_W'(1)) == num_q;
  // Once every data word is written, the next packed word is the checksum.
  assign ck_phase  = (word_idx_q == num_q);

  byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok),
    .in_fire  (in_fire),
    .in_byte  (byte_data),
    .word     (pk_word),
    .word_full(word_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      word_idx_q  <= '0;
      num_q       <= '0;
      sum_q       <= '0;
      ck_ok_q     <= 1'b0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      num_q       <= num_d;
      sum_q       <= sum_d;
      ck_ok_q     <= ck_ok_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (oversize)                        state_d = ST_IDLE;
          else if (num_words == '0 && !CK_EN)  state_d = ST_DONE;
          else                                 state_d = ST_RECV;
        end
      end
      ST_RECV:  if (word_full) state_d = (CK_EN && ck_phase) ? ST_CHECK : ST_WRITE;
      ST_WRITE: state_d = (!CK_EN && last_word) ? ST_DONE : ST_RECV;
      ST_CHECK: state_d = ck_ok_q ? ST_DONE : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    word_idx_d  = word_idx_q;
    num_d       = num_q;
    sum_d       = sum_q;
    ck_ok_d     = ck_ok_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (start_ok) begin
      num_d      = num_words;
      word_idx_d = '0;
      sum_d      = '0;
      err_d      = oversize;
    end else if (state_q == ST_RECV && word_full) begin
      if (CK_EN && ck_phase) begin
        ck_ok_d = (pk_word == sum_q);
      end else begin
        mem_we_d    = 1'b1;
        mem_addr_d  = {{(32 - CNT_W - 2){1'b0}}, word_idx_q, 2'b00};
        mem_wdata_d = pk_word;
        sum_d       = sum_q + pk_word;
      end
    end else if (state_q == ST_WRITE) begin
      word_idx_d = word_idx_q + CNT_W'(1);
    end else if (state_q == ST_CHECK && !ck_ok_q) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    byte_ready = (state_q == ST_RECV);
    busy       = (state_q == ST_RECV) || (state_q == ST_WRITE) || (state_q == ST_CHECK);
    done       = (state_q == ST_DONE);
    core_rst   = (state_q != ST_DONE);
  end

  assign err       = err_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
